mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencer and arbiter that shares the core's single memory port between the instruction-fetch requester and the load/store requester. The decode stage flags loads and stores, and the execute stage presents them on the data requester. The block picks one requester, drives a one-outstanding-transaction request/response protocol to memory, and returns read data or write completion to the winner. Data accesses normally win; a starvation counter guarantees fetch progress.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
- STARVE_LIMIT, 4, consecutive arbitration losses by fetch before fetch is forced to win; range 1..15
- iClk  input  1  core clock; all logic on its rising edge
- iRst  input  1  synchronous, active-high reset
- iFetchReq  input  1  fetch request; held with iFetchAddr until oFetchGnt
- iFetchAddr  input  ADDR_WIDTH  fetch address
- oFetchGnt  output  1  one-cycle pulse: fetch request accepted
- oFetchValid  output  1  one-cycle pulse: oFetchData valid
- oFetchData  output  DATA_WIDTH  fetched word
- iDataReq  input  1  load/store request; held with payload until oDataGnt
- iDataWrite  input  1  1 = store, 0 = load
- iDataAddr  input  ADDR_WIDTH  load/store address
- iDataWData  input  DATA_WIDTH  store data
- iDataByteEn  input  DATA_WIDTH/8  store byte enables; loads force all-ones on memory
- oDataGnt  output  1  one-cycle pulse: data request accepted
- oDataValid  output  1  one-cycle pulse: load data valid or store complete
- oDataRData  output  DATA_WIDTH  load data
- oDataBusy  output  1  combinational: iDataReq high or data transaction in flight; pipeline stall
- oMemReq, oMemWrite  output  1  memory request and direction, held until iMemReady
- oMemAddr, oMemWData, oMemByteEn  output  ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  memory payload
- iMemReady  input  1  memory accepts the request this cycle
- iMemRValid  input  1  read response valid
- iMemRData  input  DATA_WIDTH  read response data

## Operation
- States: IDLE, FETCH_REQ, FETCH_WAIT, DATA_REQ, DATA_WAIT. Only one transaction is outstanding.
- Arbitration happens only in IDLE.
  - Data only requesting: DATA_REQ.
  - Fetch only requesting: FETCH_REQ.
  - Both requesting: DATA_REQ, unless the starve counter equals STARVE_LIMIT; then FETCH_REQ.
- Starve counter:
  - Increments, saturating, each time both request and data wins.
  - Clears on every fetch grant.
- On arbitration the winner's payload is registered onto oMem*. The matching oXGnt pulses while entering the *_REQ state.
- *_REQ: oMemReq=1, payload held stable.
  - iMemReady=1 on a read: next state is *_WAIT.
  - iMemReady=1 on a store: oDataValid pulses, next state IDLE.
- *_WAIT: oMemReq=0. When iMemRValid=1, iMemRData is registered to oFetchData/oDataRData, oXValid pulses, next state IDLE.
- Fetches are always reads: oMemWrite=0 and oMemByteEn all-ones.
- Requests arriving outside IDLE are not sampled. Requesters keep iXReq held.
- iMemRValid outside the *_WAIT states is ignored and dropped. This includes a response to a transaction killed by reset.
- oFetchData and oDataRData hold their last value between valid pulses.

## Timing
- Reset: state IDLE, starve counter 0. All registered outputs 0: oFetchGnt, oFetchValid, oFetchData, oDataGnt, oDataValid, oDataRData, oMem*.
- iRst mid-transaction aborts it immediately. No valid pulse is produced, and the requester reissues.
- Request sampled in IDLE at cycle N: oXGnt=1 and oMemReq=1 at N+1.
- Memory acceptance:
  - Store with iMemReady at cycle M: oDataValid=1 at M+1, IDLE at M+1, next oMemReq no earlier than M+2.
  - Read with iMemReady at cycle M: earliest iMemRValid is M+1. With iMemRValid at cycle K, oXValid and data appear at K+1, IDLE at K+1.
- Best-case load-to-use: 3 cycles (N request, N+1 accept, N+2 rvalid, N+3 valid).
- iMemReady in IDLE or *_WAIT is ignored.
- Memory must not assert iMemRValid in the acceptance cycle.

## Test plan
- Single fetch, addr 0x0000_0010; iMemReady at N+1, iMemRValid with 0x0050_0093 at N+2 -> oFetchGnt at N+1, oFetchValid with oFetchData=0x0050_0093 at N+3, oDataGnt never.
- Store addr 0x0000_0100, data 0xDEAD_BEEF, byte-en 0x3, iMemReady delayed 3 cycles -> oMemReq, oMemWrite, address, data and byte enables stable for all 4 cycles; oDataValid one pulse the cycle after acceptance; oDataBusy high throughout.
- Fetch and data both requesting with STARVE_LIMIT=4, data re-requesting continuously -> 4 data grants, then 1 fetch grant, counter back to 0, data wins next.
- Load with iMemRValid asserted for 2 cycles -> exactly one oDataValid pulse; the second response is dropped in IDLE.
- iRst asserted in FETCH_WAIT, then iMemRValid arrives next cycle -> no oFetchValid, all outputs 0 during reset, state IDLE; a new fetch after reset is granted normally.
- Back-to-back loads at 0x200 and 0x204, 0-wait memory -> grants 3 cycles apart, oDataRData matches each response in order.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the core's single memory port between the instruction-fetch
//   requester and the load/store requester. Exactly one memory transaction
//   may be outstanding at a time. Data accesses normally win arbitration.
//   A starvation counter forces a fetch grant after STARVE_LIMIT
//   consecutive losses, so fetch always makes progress.
//
// Ports
//   iClk, iRst              clock, synchronous active-high reset
//   iFetch*/oFetch*         fetch requester: req/addr in, gnt/valid/data out
//   iData*/oData*           load/store requester: req/write/addr/wdata/byte-en
//                           in, gnt/valid/rdata out, oDataBusy pipeline stall
//   oMem*/iMem*             memory port: req/write/addr/wdata/byte-en out,
//                           ready/rvalid/rdata in
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic                    iFetchReq,
  input  logic [ADDR_WIDTH-1:0]   iFetchAddr,
  output logic                    oFetchGnt,
  output logic                    oFetchValid,
  output logic [DATA_WIDTH-1:0]   oFetchData,
  input  logic                    iDataReq,
  input  logic                    iDataWrite,
  input  logic [ADDR_WIDTH-1:0]   iDataAddr,
  input  logic [DATA_WIDTH-1:0]   iDataWData,
  input  logic [DATA_WIDTH/8-1:0] iDataByteEn,
  output logic                    oDataGnt,
  output logic                    oDataValid,
  output logic [DATA_WIDTH-1:0]   oDataRData,
  output logic                    oDataBusy,
  output logic                    oMemReq,
  output logic                    oMemWrite,
  output logic [ADDR_WIDTH-1:0]   oMemAddr,
  output logic [DATA_WIDTH-1:0]   oMemWData,
  output logic [DATA_WIDTH/8-1:0] oMemByteEn,
  input  logic                    iMemReady,
  input  logic                    iMemRValid,
  input  logic [DATA_WIDTH-1:0]   iMemRData
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH_REQ  = 3'd1,
    FETCH_WAIT = 3'd2,
    DATA_REQ   = 3'd3,
    DATA_WAIT  = 3'd4
  } state_e;

  state_e                  state_q,       state_d;
  logic [3:0]              starve_q,      starve_d;
  logic                    fetch_gnt_q,   fetch_gnt_d;
  logic                    fetch_valid_q, fetch_valid_d;
  logic [DATA_WIDTH-1:0]   fetch_data_q,  fetch_data_d;
  logic                    data_gnt_q,    data_gnt_d;
  logic                    data_valid_q,  data_valid_d;
  logic [DATA_WIDTH-1:0]   data_rdata_q,  data_rdata_d;
  logic                    mem_req_q,     mem_req_d;
  logic                    mem_write_q,   mem_write_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q,    mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q,   mem_wdata_d;
  logic [BE_WIDTH-1:0]     mem_be_q,      mem_be_d;

  // Data wins unless fetch is also waiting and has already lost STARVE_LIMIT times in a row.
  logic data_wins_s;
  assign data_wins_s = iDataReq && (!iFetchReq || (starve_q != STARVE_MAX));

  // Next-state, arbitration and registered-output computation.
  always_comb begin
    state_d       = state_q;
    starve_d      = starve_q;
    fetch_gnt_d   = 1'b0;
    fetch_valid_d = 1'b0;
    fetch_data_d  = fetch_data_q;
    data_gnt_d    = 1'b0;
    data_valid_d  = 1'b0;
    data_rdata_d  = data_rdata_q;
    mem_req_d     = mem_req_q;
    mem_write_d   = mem_write_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_be_d      = mem_be_q;

    case (state_q)
      IDLE: begin
        if (data_wins_s) begin
          state_d     = DATA_REQ;
          data_gnt_d  = 1'b1;
          mem_req_d   = 1'b1;
          mem_write_d = iDataWrite;
          mem_addr_d  = iDataAddr;
          mem_wdata_d = iDataWData;
          // Loads always read the full word regardless of requester byte enables.
          mem_be_d    = iDataWrite ? iDataByteEn : {BE_WIDTH{1'b1}};
          if (iFetchReq) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : (starve_q + 4'd1);
          end else begin
            starve_d = starve_q;
          end
        end else if (iFetchReq) begin
          state_d     = FETCH_REQ;
          fetch_gnt_d = 1'b1;
          starve_d    = 4'd0;
          mem_req_d   = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = iFetchAddr;
          mem_wdata_d = {DATA_WIDTH{1'b0}};
          mem_be_d    = {BE_WIDTH{1'b1}};
        end else begin
          state_d = IDLE;
        end
      end

      FETCH_REQ: begin
        if (iMemReady) begin
          mem_req_d = 1'b0;
          state_d   = FETCH_WAIT;
        end else begin
          state_d = FETCH_REQ;
        end
      end

      FETCH_WAIT: begin
        if (iMemRValid) begin
          fetch_data_d  = iMemRData;
          fetch_valid_d = 1'b1;
          state_d       = IDLE;
        end else begin
          state_d = FETCH_WAIT;
        end
      end

      DATA_REQ: begin
        if (iMemReady) begin
          mem_req_d = 1'b0;
          // A store completes on acceptance; a load still needs its response.
          if (mem_write_q) begin
            data_valid_d = 1'b1;
            state_d      = IDLE;
          end else begin
            state_d = DATA_WAIT;
          end
        end else begin
          state_d = DATA_REQ;
        end
      end

      DATA_WAIT: begin
        if (iMemRValid) begin
          data_rdata_d = iMemRData;
          data_valid_d = 1'b1;
          state_d      = IDLE;
        end else begin
          state_d = DATA_WAIT;
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset; reset aborts any transaction.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q       <= IDLE;
      starve_q      <= 4'd0;
      fetch_gnt_q   <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= {DATA_WIDTH{1'b0}};
      data_gnt_q    <= 1'b0;
      data_valid_q  <= 1'b0;
      data_rdata_q  <= {DATA_WIDTH{1'b0}};
      mem_req_q     <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= {ADDR_WIDTH{1'b0}};
      mem_wdata_q   <= {DATA_WIDTH{1'b0}};
      mem_be_q      <= {BE_WIDTH{1'b0}};
    end else begin
      state_q       <= state_d;
      starve_q      <= starve_d;
      fetch_gnt_q   <= fetch_gnt_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_data_q  <= fetch_data_d;
      data_gnt_q    <= data_gnt_d;
      data_valid_q  <= data_valid_d;
      data_rdata_q  <= data_rdata_d;
      mem_req_q     <= mem_req_d;
      mem_write_q   <= mem_write_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_be_q      <= mem_be_d;
    end
  end

  assign oFetchGnt   = fetch_gnt_q;
  assign oFetchValid = fetch_valid_q;
  assign oFetchData  = fetch_data_q;
  assign oDataGnt    = data_gnt_q;
  assign oDataValid  = data_valid_q;
  assign oDataRData  = data_rdata_q;
  assign oMemReq     = mem_req_q;
  assign oMemWrite   = mem_write_q;
  assign oMemAddr    = mem_addr_q;
  assign oMemWData   = mem_wdata_q;
  assign oMemByteEn  = mem_be_q;

  // Stall the pipeline while a load/store is requested or still in flight.
  assign oDataBusy = iDataReq || (state_q == DATA_REQ) || (state_q == DATA_WAIT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter. Requests are queued as
//   stimulus records; each one pushes its expected response onto a
//   per-requester scoreboard queue when it is driven, and valid pulses
//   pop and compare. A small memory model answers with a per-record
//   ready delay. Hand-written sequences cover reset and response corner cases.
module tb_mem_port_arbiter;

  logic        iClk;
  logic        iRst;
  logic        iFetchReq;
  logic [31:0] iFetchAddr;
  logic        oFetchGnt;
  logic        oFetchValid;
  logic [31:0] oFetchData;
  logic        iDataReq;
  logic        iDataWrite;
  logic [31:0] iDataAddr;
  logic [31:0] iDataWData;
  logic [3:0]  iDataByteEn;
  logic        oDataGnt;
  logic        oDataValid;
  logic [31:0] oDataRData;
  logic        oDataBusy;
  logic        oMemReq;
  logic        oMemWrite;
  logic [31:0] oMemAddr;
  logic [31:0] oMemWData;
  logic [3:0]  oMemByteEn;
  logic        iMemReady;
  logic        iMemRValid;
  logic [31:0] iMemRData;

  mem_port_arbiter #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .STARVE_LIMIT(4)
  ) dut (
    .iClk       (iClk),
    .iRst       (iRst),
    .iFetchReq  (iFetchReq),
    .iFetchAddr (iFetchAddr),
    .oFetchGnt  (oFetchGnt),
    .oFetchValid(oFetchValid),
    .oFetchData (oFetchData),
    .iDataReq   (iDataReq),
    .iDataWrite (iDataWrite),
    .iDataAddr  (iDataAddr),
    .iDataWData (iDataWData),
    .iDataByteEn(iDataByteEn),
    .oDataGnt   (oDataGnt),
    .oDataValid (oDataValid),
    .oDataRData (oDataRData),
    .oDataBusy  (oDataBusy),
    .oMemReq    (oMemReq),
    .oMemWrite  (oMemWrite),
    .oMemAddr   (oMemAddr),
    .oMemWData  (oMemWData),
    .oMemByteEn (oMemByteEn),
    .iMemReady  (iMemReady),
    .iMemRValid (iMemRValid),
    .iMemRData  (iMemRData)
  );

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  typedef struct {
    bit          is_fetch;
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          ready_delay;
    logic [31:0] exp_data;
    int          exp_gnt_lat;     // 0 = not checked
    int          exp_valid_lat;   // 0 = not checked
    int          exp_req_cycles;  // 0 = not checked
  } vec_t;

  typedef struct {
    bit          write;
    logic [31:0] data;
    int          t0;
    int          exp_lat;
    int          exp_req;
  } sb_t;

  vec_t fetch_stim_q[$];
  vec_t data_stim_q[$];
  sb_t  fetch_sb_q[$];
  sb_t  data_sb_q[$];
  bit   gnt_log[$];   // 1 = fetch grant, 0 = data grant
  int   gnt_cyc[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   fetch_driven = 1'b0;
  bit   data_driven = 1'b0;
  int   fetch_t0 = 0;
  int   data_t0 = 0;
  vec_t cur;
  bit   cur_valid = 1'b0;
  bit   data_inflight = 1'b0;
  int   req_cycles = 0;
  int   ready_cnt = 0;
  bit   rv_pending = 1'b0;
  logic [31:0] rv_data = 32'h0;
  bit   mem_auto = 1'b1;
  int   dv_count = 0;

  // Reference memory contents.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'h0050_0093;
      32'h0000_0040: return 32'h0000_0013;
      32'h0000_0200: return 32'h1111_2222;
      32'h0000_0204: return 32'h3333_4444;
      32'h0000_0300: return 32'hCAFE_F00D;
      default:       return {a[15:0], ~a[15:0]};
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event with no matching expectation (cycle %0d)", name, cyc);
  endtask

  // One clock: sample outputs, score them, run the memory model, drive requesters.
  task automatic tick();
    vec_t v;
    sb_t  e;
    @(posedge iClk);
    #1;
    cyc++;
    chk("single_gnt", 64'(oFetchGnt & oDataGnt), 64'(0));

    if (oFetchValid) begin
      if (fetch_sb_q.size() == 0) unexpected("fetch_valid_unexpected");
      else begin
        e = fetch_sb_q.pop_front();
        chk("fetch_data", 64'(oFetchData), 64'(e.data));
        if (e.exp_lat > 0) chk("fetch_valid_lat", 64'(cyc - e.t0), 64'(e.exp_lat));
        if (e.exp_req > 0) chk("fetch_req_cycles", 64'(req_cycles), 64'(e.exp_req));
      end
    end
    if (oDataValid) begin
      dv_count++;
      data_inflight = 1'b0;
      if (data_sb_q.size() == 0) unexpected("data_valid_unexpected");
      else begin
        e = data_sb_q.pop_front();
        if (!e.write) chk("data_rdata", 64'(oDataRData), 64'(e.data));
        if (e.exp_lat > 0) chk("data_valid_lat", 64'(cyc - e.t0), 64'(e.exp_lat));
        if (e.exp_req > 0) chk("data_req_cycles", 64'(req_cycles), 64'(e.exp_req));
      end
    end

    if (oFetchGnt) begin
      if (!fetch_driven || fetch_stim_q.size() == 0) unexpected("fetch_gnt_unexpected");
      else begin
        v = fetch_stim_q.pop_front();
        if (v.exp_gnt_lat > 0) chk("fetch_gnt_lat", 64'(cyc - fetch_t0), 64'(v.exp_gnt_lat));
        cur = v; cur_valid = 1'b1; ready_cnt = 0; req_cycles = 0;
        gnt_log.push_back(1'b1); gnt_cyc.push_back(cyc);
        fetch_driven = 1'b0; iFetchReq = 1'b0;
      end
    end
    if (oDataGnt) begin
      if (!data_driven || data_stim_q.size() == 0) unexpected("data_gnt_unexpected");
      else begin
        v = data_stim_q.pop_front();
        if (v.exp_gnt_lat > 0) chk("data_gnt_lat", 64'(cyc - data_t0), 64'(v.exp_gnt_lat));
        cur = v; cur_valid = 1'b1; ready_cnt = 0; req_cycles = 0;
        gnt_log.push_back(1'b0); gnt_cyc.push_back(cyc);
        data_driven = 1'b0; iDataReq = 1'b0; data_inflight = 1'b1;
      end
    end

    chk("data_busy", 64'(oDataBusy), 64'(iDataReq | data_inflight));

    if (oMemReq) begin
      req_cycles++;
      if (!cur_valid) unexpected("mem_req_unexpected");
      else begin
        chk("mem_ctrl", 64'({oMemWrite, oMemByteEn, oMemAddr}),
            64'({cur.write, (cur.write ? cur.be : 4'hF), cur.addr}));
        if (cur.write) chk("mem_wdata", 64'(oMemWData), 64'(cur.wdata));
      end
    end

    if (mem_auto) begin
      iMemReady  = 1'b0;
      iMemRValid = 1'b0;
      if (oMemReq) begin
        if (ready_cnt >= cur.ready_delay) begin
          iMemReady = 1'b1;
          ready_cnt = 0;
          if (!oMemWrite) begin
            rv_pending = 1'b1;
            rv_data = mem_word(oMemAddr);
          end
        end else begin
          ready_cnt++;
        end
      end else if (rv_pending) begin
        iMemRValid = 1'b1;
        iMemRData  = rv_data;
        rv_pending = 1'b0;
      end
    end

    if (!fetch_driven && fetch_stim_q.size() > 0) begin
      v = fetch_stim_q[0];
      iFetchReq = 1'b1; iFetchAddr = v.addr;
      fetch_t0 = cyc; fetch_driven = 1'b1;
      e.write = 1'b0; e.data = v.exp_data; e.t0 = cyc;
      e.exp_lat = v.exp_valid_lat; e.exp_req = v.exp_req_cycles;
      fetch_sb_q.push_back(e);
    end
    if (!data_driven && data_stim_q.size() > 0) begin
      v = data_stim_q[0];
      iDataReq = 1'b1; iDataWrite = v.write; iDataAddr = v.addr;
      iDataWData = v.wdata; iDataByteEn = v.be;
      data_t0 = cyc; data_driven = 1'b1;
      e.write = v.write; e.data = v.exp_data; e.t0 = cyc;
      e.exp_lat = v.exp_valid_lat; e.exp_req = v.exp_req_cycles;
      data_sb_q.push_back(e);
    end
  endtask

  function automatic bit all_idle();
    return (fetch_stim_q.size() == 0) && (data_stim_q.size() == 0) &&
           (fetch_sb_q.size() == 0) && (data_sb_q.size() == 0) &&
           !fetch_driven && !data_driven && !oMemReq && !rv_pending;
  endfunction

  task automatic run_until_idle(input string name, input int budget);
    int n = 0;
    tick();
    while (!all_idle() && n < budget) begin
      tick();
      n++;
    end
    if (!all_idle()) unexpected({name, "_timeout"});
  endtask

  task automatic queue_vec(input vec_t v);
    if (v.is_fetch) fetch_stim_q.push_back(v);
    else data_stim_q.push_back(v);
  endtask

  // Clears requester and bench state, then takes one reset cycle and checks outputs.
  task automatic reset_cycle();
    iRst = 1'b1;
    iFetchReq = 1'b0; iDataReq = 1'b0;
    iMemReady = 1'b0; iMemRValid = 1'b0;
    fetch_stim_q.delete(); data_stim_q.delete();
    fetch_sb_q.delete(); data_sb_q.delete();
    fetch_driven = 1'b0; data_driven = 1'b0;
    cur_valid = 1'b0; data_inflight = 1'b0; rv_pending = 1'b0;
    tick();
    chk("rst_ctrl", 64'({oFetchGnt, oFetchValid, oDataGnt, oDataValid, oMemReq, oMemWrite, oMemByteEn}), 64'(0));
    chk("rst_rdata", {oFetchData, oDataRData}, 64'(0));
    chk("rst_mem_payload", {oMemAddr, oMemWData}, 64'(0));
    iRst = 1'b0;
  endtask

  vec_t tbl[6];
  vec_t v;
  int   base;
  int   dv_start;
  bit   exp_order[7];

  initial begin
    iRst = 1'b1; iFetchReq = 1'b0; iFetchAddr = 32'h0;
    iDataReq = 1'b0; iDataWrite = 1'b0; iDataAddr = 32'h0;
    iDataWData = 32'h0; iDataByteEn = 4'h0;
    iMemReady = 1'b0; iMemRValid = 1'b0; iMemRData = 32'h0;

    //           fetch  write  addr           wdata          be    dly  exp_data       gnt valid req
    tbl[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 0, 32'h0050_0093, 1, 3, 1};
    tbl[1] = '{1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'h3, 3, 32'h0000_0000, 1, 5, 4};
    tbl[2] = '{1'b0, 1'b0, 32'h0000_0200, 32'h0000_0000, 4'h1, 0, 32'h1111_2222, 1, 3, 1};
    tbl[3] = '{1'b0, 1'b0, 32'h0000_0300, 32'h5555_5555, 4'h2, 2, 32'hCAFE_F00D, 1, 5, 3};
    tbl[4] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000, 4'h0, 1, 32'h0000_0013, 1, 4, 2};
    tbl[5] = '{1'b0, 1'b1, 32'h0000_0204, 32'h1234_5678, 4'hF, 0, 32'h0000_0000, 1, 2, 1};

    reset_cycle();
    reset_cycle();

    // Isolated transactions from the vector table.
    for (int i = 0; i < 6; i++) begin
      queue_vec(tbl[i]);
      run_until_idle("vec", 40);
    end

    // Contention: six loads held back to back against one fetch.
    base = gnt_log.size();
    for (int i = 0; i < 6; i++) begin
      v = '{1'b0, 1'b0, 32'h400 + 32'(i * 4), 32'h0, 4'h0, 0, 32'h0, 0, 0, 0};
      v.exp_data = mem_word(v.addr);
      queue_vec(v);
    end
    v = '{1'b1, 1'b0, 32'h0000_0500, 32'h0, 4'h0, 0, 32'h0, 0, 0, 0};
    v.exp_data = mem_word(v.addr);
    queue_vec(v);
    run_until_idle("starve", 200);
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    chk("starve_grant_count", 64'(gnt_log.size() - base), 64'(7));
    for (int i = 0; i < 7; i++) begin
      if (base + i < gnt_log.size()) chk($sformatf("starve_order_%0d", i), 64'(gnt_log[base + i]), 64'(exp_order[i]));
    end

    // Back-to-back loads with a zero-wait memory.
    base = gnt_cyc.size();
    queue_vec('{1'b0, 1'b0, 32'h0000_0200, 32'h0, 4'h0, 0, 32'h1111_2222, 1, 3, 1});
    queue_vec('{1'b0, 1'b0, 32'h0000_0204, 32'h0, 4'h0, 0, 32'h3333_4444, 0, 0, 1});
    run_until_idle("b2b", 40);
    if (gnt_cyc.size() >= base + 2) chk("b2b_gnt_spacing", 64'(gnt_cyc[base + 1] - gnt_cyc[base]), 64'(3));
    else unexpected("b2b_missing_gnt");

    // Load whose response is held two cycles: the second beat must be dropped.
    mem_auto = 1'b0;
    dv_start = dv_count;
    queue_vec('{1'b0, 1'b0, 32'h0000_0300, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 1, 3, 1});
    tick();                                   // request presented
    tick();                                   // grant, DATA_REQ
    iMemReady = 1'b1;
    tick();                                   // DATA_WAIT
    iMemReady = 1'b0; iMemRValid = 1'b1; iMemRData = 32'hCAFE_F00D;
    tick();                                   // valid pulse
    iMemRData = 32'h0BAD_0BAD;
    tick();                                   // back in IDLE, second beat ignored
    chk("rvalid2_no_second_valid", 64'(oDataValid), 64'(0));
    chk("rvalid2_rdata_hold", 64'(oDataRData), 64'(32'hCAFE_F00D));
    iMemRValid = 1'b0;
    tick();
    chk("rvalid2_pulse_count", 64'(dv_count - dv_start), 64'(1));

    // Reset in FETCH_WAIT, with the stale response arriving right after.
    queue_vec('{1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 0, 32'h0000_0013, 1, 0, 0});
    tick();                                   // request presented
    tick();                                   // grant, FETCH_REQ
    iMemReady = 1'b1;
    tick();                                   // FETCH_WAIT
    iMemReady = 1'b0;
    reset_cycle();
    chk("rst_no_fetch_valid", 64'(oFetchValid), 64'(0));
    iMemRValid = 1'b1; iMemRData = 32'hBAD0_BAD0;
    tick();
    chk("stale_rvalid_dropped", 64'(oFetchValid), 64'(0));
    chk("stale_rvalid_no_data", 64'(oFetchData), 64'(0));
    iMemRValid = 1'b0;
    mem_auto = 1'b1;
    queue_vec('{1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 32'h0050_0093, 1, 3, 1});
    run_until_idle("post_reset_fetch", 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
